data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Handshaked, parametrised data memory that replaces the combinational-read byte array behind the MEM stage. It stores word-organised, byte-enabled RAM with registered reads. Byte, half and word loads and stores work at any byte offset. Accesses that cross a word boundary are split automatically into two RAM cycles. The core stalls on `req_ready`/`resp_valid`. Sign and zero extension is done inside the block, and misaligned traffic is counted for the performance monitor.

## Interface
- `DATA_WIDTH`, 32: data and address bus width; only 32 is supported.
- `ADDR_WIDTH`, 17: byte-address bits used; memory holds 2**(ADDR_WIDTH-2) words.
- `INIT_FILE`, "": hex file loaded with `$readmemh` at word 0 in simulation; if empty, contents are undefined.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: the block accepts a request this cycle.
- `A` in DATA_WIDTH: byte address; bits above ADDR_WIDTH-1 are ignored.
- `WE` in 1: 1 = store, 0 = load.
- `AddressingControl` in 3: [1:0] selects 00 byte, 01 half, 10 word, 11 illegal; [2] = 1 zero-extends loads.
- `WD` in DATA_WIDTH: store data, taken from the low bytes.
- `resp_valid` out 1: one-cycle pulse that completes the request.
- `RD` out DATA_WIDTH: load result, valid while `resp_valid` is high; 0 for stores and errors.
- `err` out 1: qualifies `resp_valid`; set for the illegal size.
- `misaligned_count` out 16: saturating count of accepted word-crossing requests.

## Operation
- Byte order is little-endian. Byte `b` of a word sits at byte offset `b`.
- Request fields are captured on the accept edge (`req_valid & req_ready`). Inputs are don't-care at all other times.
- `off = A[1:0]`. Size is 1, 2 or 4 bytes. A request crosses a word boundary when `off + size > 4`:
  - half at offset 3;
  - word at offsets 1, 2 or 3.
- Word index is `w0 = A[ADDR_WIDTH-1:2]`; the second word is `w0+1`, wrapping modulo the depth (top word to word 0).
- FSM states:
  - IDLE: `req_ready` = 1. On accept, the word-w0 access is issued on the same edge, using the byte enables for the bytes that fall in w0.
    - Legal and crossing: go to SECOND.
    - Legal and not crossing: go to DONE.
    - Illegal size: no RAM access, no write; go to DONE with `err` = 1.
  - SECOND: the word-(w0+1) access is issued with the remaining byte enables; the w0 read data is held. Go to DONE.
  - DONE: `resp_valid` = 1, `RD` and `err` driven. Go to IDLE. `req_ready` = 0 in SECOND and DONE.
- Load assembly:
  - Bytes are gathered from w0 (and w0+1 when crossing) into the low `size` bytes.
  - The result is sign-extended from its top bit, or zero-extended when [2] = 1. [2] is ignored for word loads.
- Stores: `WD` byte `k` goes to byte address `A+k`. Only the addressed bytes change.
- `misaligned_count` increments on the accept edge of a legal crossing request and saturates at 0xFFFF.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `RD` 0, `err` 0, `misaligned_count` 0. RAM contents are not reset.
- Latency from the accept edge (cycle T):
  - non-crossing: `resp_valid` in T+1;
  - crossing: `resp_valid` in T+2;
  - illegal: `resp_valid` in T+1.
- After `resp_valid`, `req_ready` returns in the following cycle. Throughput is one request per 2 cycles (aligned) or 3 cycles (crossing).
- Store visibility: store bytes are visible to any load accepted after that store's `resp_valid`.
- Reset mid-operation: the FSM goes to IDLE immediately and no response is given. For a crossing store interrupted in SECOND, the w0 bytes are already written and the w0+1 bytes are not.
- `RD` holds its value outside `resp_valid` but is not guaranteed.

## Test plan
- Reset, then sw 0xDEADBEEF @0x100, then lw @0x100.
  - Expect `RD` = 0xDEADBEEF, `resp_valid` at T+1, `misaligned_count` = 0.
- Byte loads after the store above:
  - lb @0x103 → 0xFFFFFFDE;
  - lbu @0x103 → 0x000000DE;
  - lh @0x101 → 0xFFFFADBE;
  - lhu @0x102 → 0x0000DEAD.
- Crossing word: sw 0x11223344 @0x203, then lw @0x203.
  - Expect `RD` = 0x11223344 and `resp_valid` at T+2.
  - lbu @0x203 → 0x44; lbu @0x206 → 0x11; bytes @0x202 and @0x207 unchanged.
  - `misaligned_count` = 2.
- Wrap-around: sh 0xBEEF at byte address 2**ADDR_WIDTH-1.
  - Expect 0xEF at the top byte and 0xBE at byte 0; lhu at the same address → 0x0000BEEF.
- Illegal size: AddressingControl = 3'b011 store @0x100.
  - Expect `err` = 1 and `RD` = 0 at T+1; word 0x100 still reads 0xDEADBEEF.
- Reset and saturation:
  - Deassert `rst_n` in SECOND of a crossing sw 0xAABBCCDD @0x301. Expect bytes 0x301–0x303 = DD, CC, BB, byte 0x304 unchanged, no `resp_valid`, counter 0.
  - Preload the counter near 0xFFFF via repeated crossing accesses and confirm it holds at 0xFFFF.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
//   req_valid/req_ready : request handshake, accepted when both are high
//   A, WE, WD           : byte address, store flag, store data (low bytes)
//   AddressingControl   : [1:0] size (byte/half/word/illegal), [2] zero-extend loads
//   resp_valid, RD, err : one-cycle completion pulse, load result, illegal-size flag
interface data_mem_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] A;
    logic                  WE;
    logic [2:0]            AddressingControl;
    logic [DATA_WIDTH-1:0] WD;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] RD;
    logic                  err;

    modport master (
        output req_valid, A, WE, AddressingControl, WD,
        input  req_ready, resp_valid, RD, err
    );

    modport slave (
        input  req_valid, A, WE, AddressingControl, WD,
        output req_ready, resp_valid, RD, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-enabled data memory with registered reads. Byte/half/word
// accesses at any offset; word-crossing accesses take a second RAM cycle.
// Loads are sign/zero-extended here; crossing requests are counted.
//   clk, rst_n       : clock, async active-low reset
//   bus (slave)      : request/response handshake, see data_mem_ctrl_if
//   misaligned_count : saturating count of accepted legal word-crossing requests
module data_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_ctrl_if.slave        bus,
    output logic [15:0]           misaligned_count
);
    localparam int unsigned WW    = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 2 ** WW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [DEPTH];

    // Request decode: lay the access out over a two-word window {w0+1, w0}
    logic          accept_c;
    logic [1:0]    off_c;
    logic [1:0]    sz_c;
    logic          legal_c;
    logic [3:0]    size_mask_c;
    logic [7:0]    be8_c;
    logic [63:0]   wd64_c;
    logic          cross_c;
    logic [WW-1:0] w0_c;
    logic [WW-1:0] w1_c;
    logic          unused_addr_c;

    assign accept_c      = bus.req_valid & bus.req_ready;
    assign off_c         = bus.A[1:0];
    assign sz_c          = bus.AddressingControl[1:0];
    assign legal_c       = (sz_c != 2'b11);
    assign be8_c         = 8'({4'b0000, size_mask_c} << off_c);
    assign wd64_c        = {32'b0, bus.WD[31:0]} << {off_c, 3'b000};
    assign cross_c       = |be8_c[7:4];
    assign w0_c          = bus.A[ADDR_WIDTH-1:2];
    assign w1_c          = w0_c + WW'(1);
    assign unused_addr_c = ^{bus.A[DATA_WIDTH-1:ADDR_WIDTH]};

    always_comb begin
        size_mask_c = 4'b0000;
        case (sz_c)
            2'b00:   size_mask_c = 4'b0001;
            2'b01:   size_mask_c = 4'b0011;
            2'b10:   size_mask_c = 4'b1111;
            default: size_mask_c = 4'b0000;
        endcase
    end

    // Fields held for the second word and for load assembly
    logic [1:0]    off_q;
    logic [1:0]    sz_q;
    logic          zext_q;
    logic          we_q;
    logic [WW-1:0] w1_q;
    logic [3:0]    be_hi_q;
    logic [31:0]   wd_hi_q;
    logic [31:0]   hold0_q;

    // Gather size bytes starting at off from {hi, lo}, then extend
    function automatic logic [31:0] assemble(input logic [31:0] lo, input logic [31:0] hi,
                                             input logic [1:0] off, input logic [1:0] sz,
                                             input logic zext);
        logic [63:0] dw;
        logic [31:0] r;
        dw = {hi, lo} >> {off, 3'b000};
        case (sz)
            2'b00:   r = zext ? {24'b0, dw[7:0]}  : {{24{dw[7]}}, dw[7:0]};
            2'b01:   r = zext ? {16'b0, dw[15:0]} : {{16{dw[15]}}, dw[15:0]};
            default: r = dw[31:0];
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = (legal_c && cross_c) ? SECOND : DONE;
            SECOND:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port plus request capture; the RAM is never reset
    always_ff @(posedge clk) begin
        if (accept_c) begin
            off_q   <= off_c;
            sz_q    <= sz_c;
            zext_q  <= bus.AddressingControl[2];
            we_q    <= bus.WE;
            w1_q    <= w1_c;
            be_hi_q <= be8_c[7:4];
            wd_hi_q <= wd64_c[63:32];
            if (legal_c) begin
                hold0_q <= mem[w0_c];
                for (int b = 0; b < 4; b++) begin
                    if (bus.WE && be8_c[b]) mem[w0_c][b*8 +: 8] <= wd64_c[b*8 +: 8];
                end
            end
        end
        if (state_q == SECOND) begin
            for (int b = 0; b < 4; b++) begin
                if (we_q && be_hi_q[b]) mem[w1_q][b*8 +: 8] <= wd_hi_q[b*8 +: 8];
            end
        end
    end

    // Registered response, handshake and counter
    logic        ready_q;
    logic        resp_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            rd_q    <= 32'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'b0;
        end else begin
            ready_q <= (state_d == IDLE);
            resp_q  <= (state_d == DONE);
            if (accept_c) begin
                err_q <= !legal_c;
                if (!legal_c || bus.WE)
                    rd_q <= 32'b0;
                else if (!cross_c)
                    rd_q <= assemble(mem[w0_c], 32'b0, off_c, sz_c, bus.AddressingControl[2]);
                if (legal_c && cross_c && cnt_q != 16'hFFFF)
                    cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == SECOND)
                rd_q <= we_q ? 32'b0 : assemble(hold0_q, mem[w1_q], off_q, sz_q, zext_q);
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.resp_valid   = resp_q;
    assign bus.RD           = rd_q;
    assign bus.err          = err_q;
    assign misaligned_count = cnt_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] misaligned_count;

    data_mem_ctrl_if bus ();

    data_mem_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .misaligned_count (misaligned_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  ac;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [2:0] ac, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic e,
                       input int lat, input logic [15:0] cnt);
        vec_t v;
        v.we = we; v.ac = ac; v.a = a; v.wd = wd;
        v.exp_rd = rd; v.exp_err = e; v.exp_lat = lat; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one request; lat = cycles from accept edge to resp_valid, 0 on timeout
    task automatic do_req(input logic we, input logic [2:0] ac, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat);
        int waited;
        rd = 32'b0; e = 1'b0; lat = 0; waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: got 0 want 1");
            return;
        end
        bus.req_valid = 1'b1;
        bus.WE = we;
        bus.AddressingControl = ac;
        bus.A = a;
        bus.WD = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.A = 32'hx;
        bus.WD = 32'hx;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = c;
                rd = bus.RD;
                e = bus.err;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          seen;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.WE = 1'b0;
        bus.AddressingControl = 3'b000;
        bus.A = 32'b0;
        bus.WD = 32'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp",  32'(bus.resp_valid), 32'd0);
        check("rst_rd",    bus.RD, 32'd0);
        check("rst_err",   32'(bus.err), 32'd0);
        check("rst_cnt",   32'(misaligned_count), 32'd0);
        rst_n = 1'b1;

        //   we    ac      addr         wd            rd           err lat cnt
        add(1'b1, 3'b010, 32'h100,     32'hDEADBEEF, 32'h0,        0, 1, 0);
        add(1'b0, 3'b010, 32'h100,     32'h0,        32'hDEADBEEF, 0, 1, 0);
        add(1'b0, 3'b000, 32'h103,     32'h0,        32'hFFFFFFDE, 0, 1, 0);
        add(1'b0, 3'b100, 32'h103,     32'h0,        32'h000000DE, 0, 1, 0);
        add(1'b0, 3'b001, 32'h101,     32'h0,        32'hFFFFADBE, 0, 1, 0);
        add(1'b0, 3'b101, 32'h102,     32'h0,        32'h0000DEAD, 0, 1, 0);
        add(1'b1, 3'b010, 32'h200,     32'h55667788, 32'h0,        0, 1, 0);
        add(1'b1, 3'b010, 32'h204,     32'h99AABBCC, 32'h0,        0, 1, 0);
        add(1'b1, 3'b010, 32'h203,     32'h11223344, 32'h0,        0, 2, 1);
        add(1'b0, 3'b010, 32'h203,     32'h0,        32'h11223344, 0, 2, 2);
        add(1'b0, 3'b100, 32'h203,     32'h0,        32'h00000044, 0, 1, 2);
        add(1'b0, 3'b100, 32'h206,     32'h0,        32'h00000011, 0, 1, 2);
        add(1'b0, 3'b100, 32'h202,     32'h0,        32'h00000066, 0, 1, 2);
        add(1'b0, 3'b100, 32'h207,     32'h0,        32'h00000099, 0, 1, 2);
        add(1'b0, 3'b101, 32'h203,     32'h0,        32'h00003344, 0, 2, 3);
        add(1'b0, 3'b010, 32'h204,     32'h0,        32'h99112233, 0, 1, 3);
        add(1'b0, 3'b001, 32'h205,     32'h0,        32'h00001122, 0, 1, 3);
        add(1'b1, 3'b011, 32'h100,     32'hCAFEF00D, 32'h0,        1, 1, 3);
        add(1'b0, 3'b010, 32'h100,     32'h0,        32'hDEADBEEF, 0, 1, 3);
        add(1'b0, 3'b111, 32'h101,     32'h0,        32'h0,        1, 1, 3);
        add(1'b1, 3'b001, 32'h1FFFF,   32'h0000BEEF, 32'h0,        0, 2, 4);
        add(1'b0, 3'b100, 32'h1FFFF,   32'h0,        32'h000000EF, 0, 1, 4);
        add(1'b0, 3'b100, 32'h0,       32'h0,        32'h000000BE, 0, 1, 4);
        add(1'b0, 3'b101, 32'h1FFFF,   32'h0,        32'h0000BEEF, 0, 2, 5);
        add(1'b0, 3'b000, 32'h20000,   32'h0,        32'hFFFFFFBE, 0, 1, 5);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].ac, vecs[i].a, vecs[i].wd, rd, e, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_cnt", i), 32'(misaligned_count), 32'(vecs[i].exp_cnt));
        end

        // Reset while a crossing store sits in SECOND
        do_req(1'b1, 3'b010, 32'h300, 32'h00000000, rd, e, lat);
        do_req(1'b1, 3'b010, 32'h304, 32'h12345678, rd, e, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.WE = 1'b1;
        bus.AddressingControl = 3'b010;
        bus.A = 32'h301;
        bus.WD = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("midrst_no_resp", 32'(seen), 32'd0);
        check("midrst_cnt", 32'(misaligned_count), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("postrst_no_resp", 32'(seen), 32'd0);
        do_req(1'b0, 3'b100, 32'h301, 32'h0, rd, e, lat);
        check("midrst_b301", rd, 32'h000000DD);
        do_req(1'b0, 3'b100, 32'h302, 32'h0, rd, e, lat);
        check("midrst_b302", rd, 32'h000000CC);
        do_req(1'b0, 3'b100, 32'h303, 32'h0, rd, e, lat);
        check("midrst_b303", rd, 32'h000000BB);
        do_req(1'b0, 3'b100, 32'h304, 32'h0, rd, e, lat);
        check("midrst_b304", rd, 32'h00000078);

        // Saturation: preset the counter near the top, then keep crossing
        @(negedge clk);
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        do_req(1'b0, 3'b010, 32'h203, 32'h0, rd, e, lat);
        check("sat_1", 32'(misaligned_count), 32'h0000FFFE);
        do_req(1'b0, 3'b010, 32'h203, 32'h0, rd, e, lat);
        check("sat_2", 32'(misaligned_count), 32'h0000FFFF);
        do_req(1'b0, 3'b010, 32'h203, 32'h0, rd, e, lat);
        check("sat_3", 32'(misaligned_count), 32'h0000FFFF);
        do_req(1'b0, 3'b001, 32'h1FFFF, 32'h0, rd, e, lat);
        check("sat_4", 32'(misaligned_count), 32'h0000FFFF);
        check("sat_4_rd", rd, 32'hFFFFBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
